// File: rtl/exe_div_unit.sv
// Multi-cycle 32-bit integer divider for the EXE stage (div.w / mod.w / div.wu / mod.wu).
// Restoring algorithm: one quotient bit per cycle, then one cycle for sign fix-up into the result register.
module exe_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_valid,
  input  logic [3:0]  div_op,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_cancel,
  input  logic        out_ready,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic        steps_done_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] dsr_reg;
  logic [31:0] result_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        is_mod_reg;
  logic        dzero_reg;

  logic        start;
  logic        op_signed;
  logic [31:0] abs_src1;
  logic [31:0] abs_src2;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] q_final;
  logic [31:0] r_final;
  logic [31:0] result_next;

  // div_op is {div_w, mod_w, div_wu, mod_wu}
  assign start     = div_valid && (|div_op) && !div_cancel;
  assign op_signed = div_op[3] | div_op[2];

  always_comb begin
    abs_src1 = div_src1;
    abs_src2 = div_src2;
    if (op_signed && div_src1[31]) abs_src1 = -div_src1;
    if (op_signed && div_src2[31]) abs_src2 = -div_src2;
  end

  // One restoring step: the 33-bit compare keeps 0x80000000 magnitudes exact.
  always_comb begin
    shifted  = {rem_reg, quo_reg[31]};
    diff     = shifted - {1'b0, dsr_reg};
    ge       = (shifted >= {1'b0, dsr_reg});
    rem_next = ge ? diff[31:0] : shifted[31:0];
    quo_next = {quo_reg[30:0], ge};
  end

  // A zero divisor leaves the quotient all-ones and the remainder equal to the
  // dividend magnitude; restoring the dividend sign gives back src1 exactly.
  always_comb begin
    q_final     = q_neg_reg ? -quo_reg : quo_reg;
    r_final     = r_neg_reg ? -rem_reg : rem_reg;
    if (dzero_reg) q_final = 32'hFFFF_FFFF;
    result_next = is_mod_reg ? r_final : q_final;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 5'd0;
      steps_done_reg <= 1'b0;
      rem_reg        <= 32'd0;
      quo_reg        <= 32'd0;
      dsr_reg        <= 32'd0;
      result_reg     <= 32'd0;
      q_neg_reg      <= 1'b0;
      r_neg_reg      <= 1'b0;
      is_mod_reg     <= 1'b0;
      dzero_reg      <= 1'b0;
    end else if (div_cancel) begin
      state_reg      <= IDLE;
      cnt_reg        <= 5'd0;
      steps_done_reg <= 1'b0;
      result_reg     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            rem_reg        <= 32'd0;
            quo_reg        <= abs_src1;
            dsr_reg        <= abs_src2;
            q_neg_reg      <= op_signed && (div_src1[31] ^ div_src2[31]);
            r_neg_reg      <= op_signed && div_src1[31];
            is_mod_reg     <= div_op[2] | div_op[0];
            dzero_reg      <= (div_src2 == 32'd0);
            cnt_reg        <= 5'd0;
            steps_done_reg <= 1'b0;
            state_reg      <= BUSY;
          end
        end
        BUSY: begin
          if (!steps_done_reg) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 5'd1;
            if (cnt_reg == 5'd31) steps_done_reg <= 1'b1;
          end else begin
            // extra cycle after the 32 steps registers the signed result
            result_reg     <= result_next;
            steps_done_reg <= 1'b0;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            result_reg <= 32'd0;
            state_reg  <= IDLE;
          end
        end
        default: begin
          result_reg <= 32'd0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign div_busy   = (state_reg != IDLE);
  assign div_done   = (state_reg == DONE);
  assign div_result = result_reg;

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: driver pushes reference results, monitor pops on div_done.
module tb_exe_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_valid;
  logic [3:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        out_ready;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;

  exe_div_unit dut (
    .clk(clk), .reset(reset), .div_valid(div_valid), .div_op(div_op),
    .div_src1(div_src1), .div_src2(div_src2), .div_cancel(div_cancel),
    .out_ready(out_ready), .div_busy(div_busy), .div_done(div_done),
    .div_result(div_result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [3:0] OP_DIV_W  = 4'b1000;
  localparam logic [3:0] OP_MOD_W  = 4'b0100;
  localparam logic [3:0] OP_DIV_WU = 4'b0010;
  localparam logic [3:0] OP_MOD_WU = 4'b0001;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned start_cyc;
    int          hold;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic with the ISA's special cases.
  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic        sgn;
    logic        want_rem;
    logic [31:0] q;
    logic [31:0] r;
    sgn      = op[3] | op[2];
    want_rem = op[2] | op[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return want_rem ? r : q;
  endfunction

  function automatic exp_t make_exp(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input int unsigned st, input int hold);
    exp_t e;
    e.result    = ref_model(op, a, b);
    e.op        = op;
    e.a         = a;
    e.b         = b;
    e.start_cyc = st;
    e.hold      = hold;
    return e;
  endfunction

  // All driver tasks are entered and left just after a falling edge.
  task automatic wait_idle();
    int n = 0;
    while (div_busy) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("idle_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 || div_busy) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        check("drain_timeout", sb_q.size(), 32'd0);
        return;
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    wait_idle();
    out_ready = (hold == 0);
    div_valid = 1'b1;
    div_op    = op;
    div_src1  = a;
    div_src2  = b;
    sb_q.push_back(make_exp(op, a, b, cyc + 1, hold));
    @(negedge clk);
    div_valid = 1'b0;
    div_op    = 4'b0000;
    div_src1  = $urandom;
    div_src2  = $urandom;
    check("busy_after_start", {31'd0, div_busy}, 32'd1);
  endtask

  // Monitor: pops one expectation per result, checks latency, hold stability and release.
  initial begin
    bit          done_seen = 1'b0;
    int          held = 0;
    logic [31:0] first = 32'd0;
    exp_t        e;
    e = make_exp(OP_DIV_W, 32'd0, 32'd1, 0, 0);
    forever begin
      @(negedge clk);
      if (div_done) begin
        if (!done_seen) begin
          done_seen = 1'b1;
          held      = 0;
          first     = div_result;
          if (sb_q.size() == 0) begin
            check("unexpected_done", {31'd0, div_done}, 32'd0);
            e.hold = 0;
          end else begin
            e = sb_q.pop_front();
            check("result", div_result, e.result);
            check("latency", cyc - e.start_cyc, 32'd33);
            $display("txn op=%b a=%h b=%h result=%h expected=%h", e.op, e.a, e.b,
                     div_result, e.result);
          end
        end else begin
          held++;
          check("hold_result", div_result, first);
        end
        if (held >= e.hold) out_ready = 1'b1;
      end else if (done_seen) begin
        done_seen = 1'b0;
        check("hold_cycles", held, e.hold);
        check("busy_after_done", {31'd0, div_busy}, 32'd0);
        check("result_cleared", div_result, 32'd0);
      end
    end
  end

  initial begin
    int unsigned start_a;
    int unsigned start_b;
    int          n;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1; div_valid = 1'b0; div_op = 4'b0000; div_src1 = 32'd0; div_src2 = 32'd0;
    div_cancel = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    check("reset_done", {31'd0, div_done}, 32'd0);
    check("reset_result", div_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(OP_DIV_W,  32'd100,          32'd7,          0);
    issue(OP_MOD_W,  32'd100,          32'd7,          0);
    issue(OP_MOD_W,  32'hFFFF_FFF9,    32'd2,          0);
    issue(OP_DIV_W,  32'hFFFF_FFF9,    32'd2,          0);
    issue(OP_DIV_W,  32'h8000_0000,    32'hFFFF_FFFF,  0);
    issue(OP_MOD_W,  32'h8000_0000,    32'hFFFF_FFFF,  0);
    issue(OP_DIV_WU, 32'hFFFF_FFFF,    32'd2,          0);
    issue(OP_MOD_WU, 32'hFFFF_FFFF,    32'd2,          0);
    issue(OP_DIV_W,  32'd5,            32'd0,          0);
    issue(OP_MOD_WU, 32'h0000_1234,    32'd0,          0);
    issue(OP_MOD_W,  32'hFFFF_FFF9,    32'd0,          1);
    issue(OP_DIV_W,  32'd1000,         32'd3,          5);
    wait_drain();

    // Back-to-back: div_valid held high through DONE; second start lands 35 cycles later.
    out_ready = 1'b1;
    div_valid = 1'b1; div_op = OP_DIV_W; div_src1 = 32'd77; div_src2 = 32'd5;
    start_a = cyc + 1;
    sb_q.push_back(make_exp(OP_DIV_W, 32'd77, 32'd5, start_a, 0));
    @(negedge clk);
    div_op = OP_MOD_WU; div_src1 = 32'hDEAD_BEEF; div_src2 = 32'd1000;
    start_b = start_a + 35;
    sb_q.push_back(make_exp(OP_MOD_WU, 32'hDEAD_BEEF, 32'd1000, start_b, 0));
    n = 0;
    while (cyc < start_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    div_valid = 1'b0; div_op = 4'b0000;
    wait_drain();

    // Cancel on BUSY cycle 10, then a clean restart.
    div_valid = 1'b1; div_op = OP_DIV_W; div_src1 = 32'd100; div_src2 = 32'd7;
    @(negedge clk);
    div_valid = 1'b0; div_op = 4'b0000;
    repeat (9) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    check("cancel_busy", {31'd0, div_busy}, 32'd0);
    check("cancel_done", {31'd0, div_done}, 32'd0);
    repeat (40) @(negedge clk);
    issue(OP_DIV_W, 32'd9, 32'd3, 0);
    wait_drain();

    // Start and cancel in the same cycle: must stay idle.
    div_valid = 1'b1; div_op = OP_DIV_W; div_src1 = 32'd50; div_src2 = 32'd5; div_cancel = 1'b1;
    @(negedge clk);
    div_valid = 1'b0; div_op = 4'b0000; div_cancel = 1'b0;
    check("start_cancel_busy", {31'd0, div_busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Reset in the middle of an operation.
    div_valid = 1'b1; div_op = OP_MOD_W; div_src1 = 32'd12345; div_src2 = 32'd17;
    @(negedge clk);
    div_valid = 1'b0; div_op = 4'b0000;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'd0, div_busy}, 32'd0);
    check("midreset_result", div_result, 32'd0);
    issue(OP_MOD_W, 32'd12345, 32'd17, 0);

    for (int i = 0; i < 40; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        3: b = -($urandom_range(1, 100));
        4: begin b = $urandom; a = 32'h8000_0000; end
        default: b = $urandom;
      endcase
      issue(op, a, b, $urandom_range(0, 3));
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exe_div_unit.md
# exe_div_unit

Multi-cycle integer divider unit for the EXE stage: accepts `div.w`, `mod.w`, `div.wu` and `mod.wu` from the decoded `divmul_op` field and computes one quotient bit per cycle in a 32-step restoring loop. While an operation is in flight it holds the EXE stage. It presents a single 32-bit result with a done/ready handshake, and aborts cleanly on pipeline flush. One instance sits beside the ALU; EXE uses `es_ready_go = !(|div_op) || div_done`.

## Interface
- No parameters; data width is fixed at 32.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `div_valid` in 1: EXE holds a valid instruction (gate with `es_valid`).
- `div_op` in 4: one-hot `{div_w, mod_w, div_wu, mod_wu}` (= `divmul_op[3:0]`); all-zero = not a divide.
- `div_src1` in 32: dividend (`rj_value`).
- `div_src2` in 32: divisor (`rkd_value`).
- `div_cancel` in 1: flush; abort any operation.
- `out_ready` in 1: EXE can hand result to MEM this cycle (`ms_allowin`).
- `div_busy` out 1: unit not IDLE.
- `div_done` out 1: `div_result` valid.
- `div_result` out 32: quotient or remainder per latched op.

## Operation
- **States:**
  - IDLE: start = `div_valid && |div_op && !div_cancel`. On start, latch the following, clear the counter and go to BUSY:
    - `|src1|` and `|src2|` for signed ops, raw values for unsigned ops;
    - quotient sign = `src1[31]^src2[31]` (signed ops only);
    - remainder sign = `src1[31]` (signed ops only);
    - the op.
  - BUSY: each cycle shift `{rem,dvd}` left by 1. If `rem >= divisor`, subtract and set the quotient LSB to 1. Compare in 33 bits. Counter 0..31; at 31 go to DONE.
  - DONE: apply sign fix-up in the final registered result, then hold. On `out_ready=1`, go to IDLE.
- **`div_cancel`:** in any state, go to IDLE next edge with `div_done=0`. Cancel beats start in the same cycle.
- **DONE exit:** DONE→IDLE does not start a new op in the same edge. A new start is sampled in IDLE in the following cycle.
- **Ignored inputs:** inputs are ignored outside IDLE and may change freely once latched.
- **Divide by zero** (any op): quotient = `0xFFFFFFFF`, remainder = `src1` unmodified. No sign fix-up is applied.
- **Signed overflow** (`0x80000000 / 0xFFFFFFFF`): quotient = `0x80000000`, remainder = `0`. This falls out of magnitude arithmetic plus fix-up and must hold.
- **Magnitude of `0x80000000`:** taken as unsigned `0x80000000` (no overflow in the 33-bit path).
- **Outputs:**
  - `div_busy = (state != IDLE)`;
  - `div_done = (state == DONE)`;
  - `div_result` is 0 except in DONE.
- **Non-divide ops:** `div_op` with more than one bit set is illegal. The decoder never produces it; behaviour is unspecified.

## Timing
- **Reset:** state = IDLE, counter = 0; `div_busy=0`, `div_done=0`, `div_result=0`.
- **Latency:** start sampled at edge E0. BUSY covers cycles after E0..E32; `div_done` rises after edge E33 and stays high until the edge where `out_ready=1`.
- **Minimum occupancy:** 34 cycles when `out_ready` is already high in DONE.
- **Back-to-back:** the second start is sampled one cycle after DONE exit, so consecutive divides are 35 cycles apart.
- **Cancel:** asserted in cycle k, `div_busy=0` after the next edge.
- **Reset mid-op:** identical to cancel, and all datapath registers are cleared.
- **Stable outputs:** `div_result` is stable for the whole DONE interval.

## Test plan
- **`div.w` positive:** 100 / 7 → `div_result=14` and `div_done` 33 cycles after start. Then `mod.w` 100 % 7 → 2.
- **Signed cases:**
  - `mod.w` -7 % 2 → `0xFFFFFFFF`;
  - `div.w` -7 / 2 → `0xFFFFFFFD`;
  - `div.w` `0x80000000` / `0xFFFFFFFF` → `0x80000000`, and `mod.w` → 0.
- **Unsigned:** `div.wu` `0xFFFFFFFF` / 2 → `0x7FFFFFFF`; `mod.wu` → 1.
- **Divide by zero:** `div.w` 5 / 0 → `0xFFFFFFFF`; `mod.wu` `0x1234` / 0 → `0x1234`.
- **Cancel and restart:**
  - start `div.w` 100 / 7 and assert `div_cancel` on BUSY cycle 10 → `div_busy=0` next cycle, `div_done` never rises;
  - start `div.w` 9 / 3 → 3 after 33 cycles;
  - start and cancel in the same cycle → stays IDLE.
- **Output hold:** `out_ready=0` for 5 cycles in DONE → `div_done` and `div_result` held. Then `out_ready=1` → IDLE next edge, with a fresh `div_valid` held high sampled only one cycle later.
